// File: rtl/search_cmp8.sv
// Successive-approximation search engine: drives the comparator probe operand and
// narrows [lo, hi] from its one-hot compare result until the hidden target is found.
module search_cmp8 #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [2:0]       iCmp,
    output logic [WIDTH-1:0] oProbe,
    output logic             oBusy,
    output logic             oDone,
    output logic             oFound,
    output logic             oErr,
    output logic [WIDTH-1:0] oResult,
    output logic [3:0]       oSteps
);

    // Handshake: iStart is taken only in IDLE (never queued); oBusy is high from the
    // accepting edge until the edge that raises the single-cycle oDone pulse, and
    // oFound/oErr/oResult/oSteps are valid from that edge until the next accepted start.
    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    localparam logic [WIDTH:0]   HiInit    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   One       = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] ProbeInit = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] ProbeMax  = '1;

    state_t           state, stateNext;
    logic [WIDTH:0]   lo, hi, loNext, hiNext;
    logic [WIDTH+1:0] midSum;
    logic [WIDTH-1:0] probeNext, resultNext;
    logic [3:0]       stepsNext;
    logic             busyNext, doneNext, foundNext, errNext, advance;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state   <= IDLE;
            lo      <= '0;
            hi      <= '0;
            oProbe  <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oFound  <= 1'b0;
            oErr    <= 1'b0;
            oResult <= '0;
            oSteps  <= '0;
        end else begin
            state   <= stateNext;
            lo      <= loNext;
            hi      <= hiNext;
            oProbe  <= probeNext;
            oBusy   <= busyNext;
            oDone   <= doneNext;
            oFound  <= foundNext;
            oErr    <= errNext;
            oResult <= resultNext;
            oSteps  <= stepsNext;
        end
    end

    always_comb begin
        stateNext  = state;
        loNext     = lo;
        hiNext     = hi;
        probeNext  = oProbe;
        busyNext   = oBusy;
        doneNext   = 1'b0;
        foundNext  = oFound;
        errNext    = oErr;
        resultNext = oResult;
        stepsNext  = oSteps;
        advance    = 1'b0;

        case (state)
            IDLE: begin
                if (iStart) begin
                    loNext     = '0;
                    hiNext     = HiInit;
                    probeNext  = ProbeInit;
                    stepsNext  = '0;
                    foundNext  = 1'b0;
                    errNext    = 1'b0;
                    resultNext = '0;
                    busyNext   = 1'b1;
                    stateNext  = CMP;
                end
            end
            CMP: begin
                // Every probe ends the search unless the interval is still non-empty.
                stepsNext = oSteps + 4'd1;
                stateNext = DONE;
                busyNext  = 1'b0;
                doneNext  = 1'b1;
                case (iCmp)
                    3'b010: begin
                        resultNext = oProbe;
                        foundNext  = 1'b1;
                    end
                    3'b100: begin
                        if (oProbe != ProbeMax) begin
                            loNext  = {1'b0, oProbe} + One;
                            advance = !(loNext > hi);
                        end
                    end
                    3'b001: begin
                        if (oProbe != '0) begin
                            hiNext  = {1'b0, oProbe} - One;
                            advance = !(lo > hiNext);
                        end
                    end
                    default: begin
                        errNext   = 1'b1;
                        foundNext = 1'b0;
                    end
                endcase
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Midpoint of the updated interval; one extra bit keeps the sum from wrapping.
        midSum = {1'b0, loNext} + {1'b0, hiNext};
        if (advance) begin
            stateNext = CMP;
            busyNext  = 1'b1;
            doneNext  = 1'b0;
            probeNext = midSum[WIDTH:1];
        end
    end

endmodule

// File: tb/tb_search_cmp8.sv
// Bench for search_cmp8: a behavioural comparator answers each probe, and a plain
// integer binary-search model predicts the probe sequence and final report.
module tb_search_cmp8;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iStart = 1'b0;
    logic [2:0] iCmp;
    logic [7:0] oProbe, oResult;
    logic       oBusy, oDone, oFound, oErr;
    logic [3:0] oSteps;

    logic [7:0] tgt = 8'd0;
    logic       faultNow = 1'b0;
    logic [7:0] expQ[$];
    int         checks = 0;
    int         errors = 0;

    search_cmp8 #(.WIDTH(8)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iCmp(iCmp),
        .oProbe(oProbe), .oBusy(oBusy), .oDone(oDone), .oFound(oFound),
        .oErr(oErr), .oResult(oResult), .oSteps(oSteps)
    );

    always #5 iClk = ~iClk;

    // Behavioural comparator; faultNow forces an illegal all-zero code.
    assign iCmp = faultNow ? 3'b000 : {tgt > oProbe, tgt == oProbe, tgt < oProbe};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Plain binary search over integers; an illegal code at probe index faultIdx aborts.
    task automatic model(input int t, input int faultIdx, output int steps,
                         output int found, output int err, output int res);
        int lo, hi, p;
        lo = 0; hi = 255; steps = 0; found = 0; err = 0; res = 0;
        expQ.delete();
        while (lo <= hi) begin
            p = (lo + hi) / 2;
            expQ.push_back(p[7:0]);
            steps++;
            if (steps - 1 == faultIdx) begin
                err = 1;
                break;
            end
            if (p == t) begin
                found = 1;
                res = t;
                break;
            end
            if (t > p) lo = p + 1;
            else hi = p - 1;
        end
    endtask

    task automatic runSearch(input int t, input int faultIdx, input int pulseIdx);
        int expSteps, expFound, expErr, expRes, c;
        bit gotDone;
        tgt = t[7:0];
        model(t, faultIdx, expSteps, expFound, expErr, expRes);
        @(negedge iClk);
        iStart = 1'b1;
        faultNow = 1'b0;
        c = 0;
        gotDone = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge iClk);
            iStart = (cyc == pulseIdx);
            faultNow = 1'b0;
            if (oDone) begin
                gotDone = 1;
                break;
            end
            check("busy", oBusy, 1);
            if (expQ.size() == 0) begin
                check("probe_overrun", c, expSteps - 1);
                break;
            end
            check("probe", oProbe, expQ.pop_front());
            faultNow = (cyc == faultIdx);
            c++;
        end
        iStart = 1'b0;
        faultNow = 1'b0;
        check("done_seen", gotDone, 1);
        if (gotDone) begin
            check("done_busy", oBusy, 0);
            check("found", oFound, expFound);
            check("err", oErr, expErr);
            check("result", oResult, expRes);
            check("steps", oSteps, expSteps);
            check("probes_left", expQ.size(), 0);
            @(negedge iClk);
            check("done_pulse", oDone, 0);
            check("found_hold", oFound, expFound);
            check("steps_hold", oSteps, expSteps);
        end
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_probe"}, oProbe, 0);
        check({tag, "_busy"}, oBusy, 0);
        check({tag, "_done"}, oDone, 0);
        check({tag, "_found"}, oFound, 0);
        check({tag, "_err"}, oErr, 0);
        check({tag, "_result"}, oResult, 0);
        check({tag, "_steps"}, oSteps, 0);
    endtask

    initial begin
        int t;
        bit sawDone;
        repeat (3) @(negedge iClk);
        checkResetValues("rst");
        iRst = 1'b0;
        @(negedge iClk);
        checkResetValues("idle");

        runSearch(166, -1, -1);
        runSearch(255, -1, -1);
        runSearch(0, -1, -1);
        runSearch(127, -1, -1);

        // Illegal code on the third probe, then a clean search clears oErr.
        runSearch(200, 2, -1);
        runSearch(200, -1, -1);

        // Start pulses during CMP must not disturb the search.
        runSearch(77, -1, 3);
        runSearch(1, -1, 0);

        // iStart held high: one probe, oDone, an IDLE cycle, then a fresh acceptance.
        tgt = 8'd127;
        @(negedge iClk);
        iStart = 1'b1;
        @(negedge iClk);
        check("hold_busy", oBusy, 1);
        check("hold_probe", oProbe, 127);
        @(negedge iClk);
        check("hold_done", oDone, 1);
        check("hold_steps", oSteps, 1);
        check("hold_result", oResult, 127);
        @(negedge iClk);
        check("hold_idle_busy", oBusy, 0);
        check("hold_idle_done", oDone, 0);
        @(negedge iClk);
        check("hold_restart_busy", oBusy, 1);
        check("hold_restart_steps", oSteps, 0);
        check("hold_restart_found", oFound, 0);
        iStart = 1'b0;
        @(negedge iClk);
        check("hold_done2", oDone, 1);
        @(negedge iClk);

        // Reset during probe 4 returns everything to reset values with no oDone.
        tgt = 8'd200;
        @(negedge iClk);
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        repeat (3) @(negedge iClk);
        check("pre_rst_busy", oBusy, 1);
        iRst = 1'b1;
        #1;
        checkResetValues("async_rst");
        @(negedge iClk);
        iRst = 1'b0;
        sawDone = 0;
        repeat (5) begin
            @(negedge iClk);
            if (oDone) sawDone = 1;
        end
        check("rst_no_done", sawDone, 0);
        checkResetValues("post_rst");

        for (int i = 0; i < 16; i++) begin
            t = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0)
                runSearch(t, $urandom_range(0, 8), -1);
            else
                runSearch(t, -1, $urandom_range(0, 10));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
